bram_dp_be: RTL

Parametrised simple dual-port block RAM: one write port with per-byte write enables and one read port. Read latency is configurable, read/write collision behaviour is selectable, and a built-in clear engine zeroes the whole array after reset or on request. Used for both instruction and data memory in the rv32i core. Replaces the fixed 32x1024 bram32 and adds the missing byte-enable path for SB/SH stores.

---
 rtl/bram_dp_be.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bram_dp_be.sv
// bram_dp_be: simple dual-port block RAM with per-byte write enables,
// configurable read latency, selectable collision behaviour and a built-in
// clear engine that zeroes the whole array after reset or on request.

module bram_dp_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0]   w_dat,
  input  logic                    w_enb,
  input  logic [DATA_WIDTH/8-1:0] w_be,
  input  logic [ADDR_W-1:0]       r_addr,
  input  logic                    r_enb,
  output logic [DATA_WIDTH-1:0]   r_dat,
  output logic                    r_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int                NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  // Reject parameter combinations the storage and pipeline cannot honour.
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("bram_dp_be: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_dp_be: READ_LATENCY must be 1 or 2");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr
    $error("bram_dp_be: ADDR_W too narrow for DEPTH");
  end

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t LP_RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_cnt;
  logic [ADDR_W-1:0]     w_cnt_nxt;

  logic                  w_busy;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_in_rng;
  logic                  w_rd_in_rng;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] r_rdat;
  logic                  r_rvalid;

  // busy comes straight from the state register, so it is glitch-free.
  assign w_busy      = (r_state == CLEAR);
  assign busy        = w_busy;
  assign w_wr_in_rng = ({1'b0, w_addr} < LP_DEPTH);
  assign w_rd_in_rng = ({1'b0, r_addr} < LP_DEPTH);
  assign w_wr_acc    = w_enb & ~w_busy & w_wr_in_rng;
  assign w_rd_acc    = r_enb & ~w_busy;
  assign w_old       = w_rd_in_rng ? r_mem[r_addr] : '0;

  // Byte-wise merge of the incoming write over the old word (write-first view).
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < NB; b++) begin
      if (w_be[b]) begin
        w_merged[8*b +: 8] = w_dat[8*b +: 8];
      end
    end
  end

  // Pick the word a read returns, honouring the collision mode.
  always_comb begin
    w_rd_word = w_old;
    if (!w_rd_in_rng) begin
      w_rd_word = '0;
    end else if (COLLISION_MODE == 1 && w_wr_acc && (w_addr == r_addr)) begin
      w_rd_word = w_merged;
    end
  end

  // Clear FSM state and sweep counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LP_RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear FSM next state: one word per edge, DEPTH edges per sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (clr_req) begin
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array write port: the clear sweep owns the array while busy.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_addr][8*b +: 8] <= w_dat[8*b +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // Single-stage read: data registered on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rdat   <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) begin
          r_rdat <= w_rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] r_p1_dat;
    logic                  r_p1_vld;

    // Two-stage read: the second stage never looks at busy, so reads in
    // flight when a sweep starts still complete with pre-clear data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_p1_dat <= '0;
        r_p1_vld <= 1'b0;
        r_rdat   <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_p1_vld <= w_rd_acc;
        if (w_rd_acc) begin
          r_p1_dat <= w_rd_word;
        end
        r_rvalid <= r_p1_vld;
        if (r_p1_vld) begin
          r_rdat <= r_p1_dat;
        end
      end
    end
  end

  assign r_dat   = r_rdat;
  assign r_valid = r_rvalid;

endmodule
